// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state encoding and requester limit for mult_arbiter
package mult_arb_pkg;
  localparam int NREQ_MAX = 8;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
endpackage

// File: rtl/comb_multiplier.sv
// comb_multiplier: full-width combinational signed multiply
module comb_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);
  assign p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin time-sharing of one signed multiplier among NREQ requesters
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_prod,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("mult_arbiter: NREQ out of range");
  end
  state_t                   state;
  logic [IW-1:0]            ptr, owner, win;
  logic                     any;
  logic [2*NREQ-1:0]        dbl;
  logic signed [WIDTH-1:0]  op_a, op_b, sel_a, sel_b;
  logic signed [2*WIDTH-1:0] prod, result;
  comb_multiplier #(.WIDTH(WIDTH)) u_mul (.a(op_a), .b(op_b), .p(prod));
  // valids rotated so bit 0 is the requester currently holding top priority
  assign dbl = {req_valid, req_valid} >> ptr;
  // first valid at or after the pointer wins; its operands are muxed out
  always_comb begin
    win   = '0;
    any   = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (dbl[i]) begin
        win = IW'((int'(ptr) + i) % NREQ);
        any = 1'b1;
      end
    for (int i = 0; i < NREQ; i++)
      if (win == IW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
  end
  assign req_ready = (state == IDLE && any) ? NREQ'(1) << win : '0;
  assign rsp_valid = (state == RESP) ? NREQ'(1) << owner : '0;
  assign rsp_prod  = (state == RESP) ? result : '0;
  assign busy      = state != IDLE;
  // accept -> multiply -> hold result until the owner takes it
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
    end else
      case (state)
        IDLE: if (any) begin
          op_a  <= sel_a;
          op_b  <= sel_b;
          owner <= win;
          ptr   <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
          state <= CALC;
        end
        CALC: begin
          result <= prod;
          state  <= RESP;
        end
        RESP: if (rsp_ready[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: vector table, directed corner sequences and random run against a transaction model
module tb_mult_arbiter;
  localparam int W = 16, N = 2;
  logic clk = 1'b0, n_rst = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [2*W-1:0] rsp_prod;
  logic busy;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mult_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_prod(rsp_prod), .busy(busy)
  );
  typedef struct {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic [2*W-1:0]      p;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    longint x;
    x = longint'(a) * longint'(b);
    return x[2*W-1:0];
  endfunction
  initial begin
    int gcount, gcycle;
    logic [2*W-1:0] held;
    vecs[0] = '{-16'sd3, 16'sd5, 32'hFFFFFFF1};
    vecs[1] = '{-16'sd32768, -16'sd32768, 32'h40000000};
    vecs[2] = '{-16'sd32768, 16'sd32767, 32'hC0008000};
    vecs[3] = '{16'sd32767, 16'sd32767, 32'h3FFF0001};
    vecs[4] = '{-16'sd1, -16'sd1, 32'h00000001};
    vecs[5] = '{16'sd7, -16'sd1, 32'hFFFFFFF9};
    vecs[6] = '{16'sd0, -16'sd1234, 32'h00000000};
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_prod", 64'(rsp_prod), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    tick;
    n_rst = 1'b1;
    // table of single operations on requester 0
    for (int v = 0; v < 7; v++) begin
      req_valid = 2'b01;
      req_a = {16'h1234, vecs[v].a};
      req_b = {16'h5678, vecs[v].b};
      rsp_ready = 2'b01;
      #1;
      chk("vec_ready", 64'(req_ready), 64'd1);
      tick;
      req_valid = '0;
      #1;
      chk("vec_calc_busy", 64'(busy), 64'd1);
      chk("vec_calc_rsp", 64'(rsp_valid), 64'd0);
      chk("vec_calc_prod", 64'(rsp_prod), 64'd0);
      tick;
      #1;
      chk("vec_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("vec_prod", 64'(rsp_prod), 64'(vecs[v].p));
      chk("vec_model", 64'(rsp_prod), 64'(ref_mul(vecs[v].a, vecs[v].b)));
      tick;
      #1;
      chk("vec_done_busy", 64'(busy), 64'd0);
    end
    // round robin with both requesters always valid
    n_rst = 1'b0;
    #1;
    n_rst = 1'b1;
    tick;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_a = {16'd3, 16'd2};
    req_b = {16'd5, 16'd4};
    gcount = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != '0) begin
        chk("rr_id", 64'(req_ready), 64'((gcount % 2) == 0 ? 1 : 2));
        gcycle = c;
        chk("rr_cycle", 64'(gcycle), 64'(3 * gcount));
        gcount++;
      end
      tick;
    end
    chk("rr_count", 64'(gcount), 64'd4);
    // backpressure on owner 0, with a non-owner ready that must be ignored
    req_valid = 2'b01;
    req_a = {16'd9, 16'd100};
    req_b = {16'd9, -16'sd7};
    rsp_ready = 2'b10;
    #1;
    chk("bp_grant", 64'(req_ready), 64'd1);
    tick;
    req_valid = 2'b11;
    #1;
    chk("bp_calc_ready", 64'(req_ready), 64'd0);
    tick;
    held = rsp_prod;
    chk("bp_prod", 64'(held), 64'h0000_0000_FFFF_FD44);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_prod", 64'(rsp_prod), 64'h0000_0000_FFFF_FD44);
      chk("bp_hold_ready", 64'(req_ready), 64'd0);
      tick;
    end
    rsp_ready = 2'b01;
    #1;
    chk("bp_release_valid", 64'(rsp_valid), 64'd1);
    chk("bp_release_ready", 64'(req_ready), 64'd0);
    tick;
    // only requester 0 valid though priority sits at 1: grant follows current valids
    req_valid = 2'b01;
    #1;
    chk("drop_grant", 64'(req_ready), 64'd1);
    tick;
    #1;
    chk("calc_busy", 64'(busy), 64'd1);
    n_rst = 1'b0;
    #1;
    chk("rst_calc_busy", 64'(busy), 64'd0);
    chk("rst_calc_rsp", 64'(rsp_valid), 64'd0);
    tick;
    n_rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("rst_next_grant", 64'(req_ready), 64'd1);
    tick;
    #1;
    chk("rst_no_stale_rsp", 64'(rsp_valid), 64'd0);
    // random traffic against a transaction-level model
    n_rst = 1'b0;
    req_valid = '0;
    #1;
    n_rst = 1'b1;
    tick;
    begin
      int m_owner, m_age, m_ptr, w;
      logic [2*W-1:0] m_prod;
      logic [N-1:0] er, ev;
      m_owner = -1;
      m_age = 0;
      m_ptr = 0;
      m_prod = '0;
      for (int c = 0; c < 1500; c++) begin
        req_valid = N'($urandom_range(0, 3));
        req_a = $urandom;
        req_b = $urandom;
        if ($urandom_range(0, 7) == 0) req_a[W-1:0] = 16'h8000;
        if ($urandom_range(0, 7) == 0) req_b[W-1:0] = 16'h8000;
        rsp_ready = N'($urandom_range(0, 3));
        #1;
        w = -1;
        if (m_owner < 0)
          for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        ev = '0;
        if (m_owner >= 0 && m_age >= 2) ev[m_owner] = 1'b1;
        chk("rnd_req_ready", 64'(req_ready), 64'(er));
        chk("rnd_rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("rnd_rsp_prod", 64'(rsp_prod), 64'(ev != '0 ? m_prod : '0));
        chk("rnd_busy", 64'(busy), 64'(m_owner >= 0));
        if (w >= 0) begin
          m_owner = w;
          m_age = 1;
          m_prod = ref_mul(req_a[w*W +: W], req_b[w*W +: W]);
          m_ptr = (w + 1) % N;
        end else if (m_owner >= 0) begin
          if (m_age >= 2 && rsp_ready[m_owner]) m_owner = -1;
          else m_age++;
        end
        tick;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
